fifo_flex: RTL and testbench
============================

FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 SHALL have parameter nrOfEntries, 16, storage depth; power of two, >= 2.
REQ-002 SHALL have parameter bitWidth, 32, data word width.
REQ-003 SHALL have parameter almostFullLevel, 12, fillCount at or above which almostFull asserts; 1..nrOfEntries.
REQ-004 SHALL have parameter almostEmptyLevel, 4, fillCount at or below which almostEmpty asserts; 0..nrOfEntries-1.
REQ-005 SHALL have parameter fwft, 0, read mode: 0 = registered read, 1 = first-word fall-through.
REQ-006 SHALL have port clock  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port push  input  1  write request.
REQ-009 SHALL have port pushData  input  bitWidth  write data.
REQ-010 SHALL have port pop  input  1  read request.
REQ-011 SHALL have port clearErrors  input  1  clears sticky error flags.
REQ-012 SHALL have port popData  output  bitWidth  read data.
REQ-013 SHALL have port popValid  output  1  popData qualifier.
REQ-014 SHALL have port full, empty, almostFull, almostEmpty  output  1 each  status flags.
REQ-015 SHALL have port fillCount  output  $clog2(nrOfEntries)+1  stored-word count.
REQ-016 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL use read/write pointers of $clog2(nrOfEntries)+1 bits (wrap bit) so all nrOfEntries entries are usable.
REQ-018 SHALL treat push as accepted iff push=1 and (full=0 or pop accepted in the same cycle).
REQ-019 SHALL treat pop as accepted iff pop=1 and empty=0; pop on empty is never accepted, even with simultaneous push.
REQ-020 SHALL, on accepted push, write pushData at write pointer and increment it modulo 2*nrOfEntries at the clock edge.
REQ-021 SHALL, on accepted pop, increment read pointer modulo 2*nrOfEntries at the clock edge.
REQ-022 SHALL update fillCount by +1 (push only), -1 (pop only), 0 (both or neither), registered, never exceeding nrOfEntries.
REQ-023 SHALL drive full = (fillCount == nrOfEntries), empty = (fillCount == 0), both decoded from registered state, no combinational path from push/pop.
REQ-024 SHALL drive almostFull = (fillCount >= almostFullLevel), almostEmpty = (fillCount <= almostEmptyLevel).
REQ-025 SHALL set overflow on push=1 when not accepted; set underflow on pop=1 when empty=1; both remain set until clearErrors or reset; set has priority over clearErrors in the same cycle.
REQ-026 SHALL, with fwft=0, register the popped word into popData on the accepting edge and assert popValid for exactly the following cycle; popData holds its last value otherwise.
REQ-027 SHALL, with fwft=1, present the oldest stored word on popData whenever empty=0 with popValid = !empty; pop acknowledges that word.
REQ-028 SHALL, with fwft=1 and empty FIFO, make a pushed word visible on popData the cycle after the push edge (1-cycle latency).
REQ-029 SHALL, with push and pop accepted in the same cycle on full FIFO, replace the popped slot; fillCount stays nrOfEntries, overflow not set.
REQ-030 SHALL not modify storage contents on rejected push.

Reset
REQ-031 SHALL, when reset=1 at a rising edge, clear both pointers, fillCount, popValid, overflow, underflow; empty=1, almostEmpty=1, full=0, almostFull=0 thereafter.
REQ-032 SHALL give reset priority over push, pop and clearErrors in the same cycle; any in-flight word is discarded.
REQ-033 SHALL reset popData to 0; storage array contents need not be reset.

Verification
REQ-034 SHALL cover fill/drain, N=16, W=32, fwft=0: push 1..16 -> full=1, fillCount=16 at push 16; 16 pops -> popData 1..16 in order, each popValid one cycle after pop, then empty=1.
REQ-035 SHALL cover overflow: 17th push on full -> overflow=1, fillCount=16, data unchanged; clearErrors -> overflow=0 next cycle.
REQ-036 SHALL cover underflow: pop on empty with push=1 -> underflow=1, fillCount=1, pushed word retained.
REQ-037 SHALL cover full + simultaneous push/pop: fillCount stays 16, popped word is oldest, new word appears last after 16 further pops; wrap pointers over 3 full cycles.
REQ-038 SHALL cover fwft=1: push 0xA5 to empty -> next cycle popData=0xA5, popValid=1 without pop; pop -> empty=1.
REQ-039 SHALL cover thresholds and mid-operation reset: fillCount 11->12 asserts almostFull, 5->4 asserts almostEmpty; reset at fillCount=7 with push=1 -> fillCount=0, empty=1, flags cleared.

Source files
------------

// File: rtl/fifo_flex.sv
// fifo_flex: parameterized synchronous FIFO with a wrap-bit pointer scheme,
// registered or first-word fall-through read, level flags and sticky errors.
module fifo_flex #(
  parameter int nrOfEntries      = 16,
  parameter int bitWidth         = 32,
  parameter int almostFullLevel  = 12,
  parameter int almostEmptyLevel = 4,
  parameter int fwft             = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push,
  input  logic [bitWidth-1:0]                pushData,
  input  logic                               pop,
  input  logic                               clearErrors,
  output logic [bitWidth-1:0]                popData,
  output logic                               popValid,
  output logic                               full,
  output logic                               empty,
  output logic                               almostFull,
  output logic                               almostEmpty,
  output logic [$clog2(nrOfEntries):0]       fillCount,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int AW = $clog2(nrOfEntries);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] FULLCNT = (AW+1)'(nrOfEntries);
  localparam logic [AW:0] AFLVL   = (AW+1)'(almostFullLevel);
  localparam logic [AW:0] AELVL   = (AW+1)'(almostEmptyLevel);

  logic [bitWidth-1:0] mem [nrOfEntries];
  logic [AW:0]         wrPtr, rdPtr, count;
  logic                popAcc, pushAcc;

  // Flags decode only registered state; no push/pop path into them.
  assign full        = (count == FULLCNT);
  assign empty       = (count == '0);
  assign almostFull  = (count >= AFLVL);
  assign almostEmpty = (count <= AELVL);
  assign fillCount   = count;

  // A pop frees a slot in the same cycle, so a full FIFO can take a push alongside it.
  assign popAcc  = pop & ~empty;
  assign pushAcc = push & (~full | popAcc);

  // Pointers and occupancy; the extra pointer bit lets all entries be used.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushAcc) wrPtr <= wrPtr + ONE;
      if (popAcc)  rdPtr <= rdPtr + ONE;
      case ({pushAcc, popAcc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are left unreset and untouched by rejected pushes.
  always_ff @(posedge clock) begin
    if (pushAcc) mem[wrPtr[AW-1:0]] <= pushData;
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & ~pushAcc)  overflow <= 1'b1;
      else if (clearErrors) overflow <= 1'b0;
      if (pop & empty)      underflow <= 1'b1;
      else if (clearErrors) underflow <= 1'b0;
    end
  end

  generate
    if (fwft == 0) begin : g_regRead
      // Registered read: capture the head word on the accepting edge; the
      // read sees the pre-edge array even when a full-FIFO push hits the same slot.
      always_ff @(posedge clock) begin
        if (reset) begin
          popData  <= '0;
          popValid <= 1'b0;
        end else begin
          popValid <= popAcc;
          if (popAcc) popData <= mem[rdPtr[AW-1:0]];
        end
      end
    end else begin : g_fwftRead
      // Fall-through: head word is shown whenever something is stored.
      assign popData  = empty ? '0 : mem[rdPtr[AW-1:0]];
      assign popValid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: drives a registered-read and a fall-through fifo_flex with the
// same stimulus and checks both against a queue-based reference model.
module tb_fifo_flex;

  localparam int N = 16;
  localparam int W = 32;

  logic          clock, reset, push, pop, clearErrors;
  logic [W-1:0]  pushData;
  logic [W-1:0]  popData0, popData1;
  logic          popValid0, popValid1;
  logic          full0, empty0, aFull0, aEmpty0, ovf0, udf0;
  logic          full1, empty1, aFull1, aEmpty1, ovf1, udf1;
  logic [4:0]    cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  fifo_flex #(.nrOfEntries(N), .bitWidth(W), .almostFullLevel(12),
              .almostEmptyLevel(4), .fwft(0)) dut0 (
    .clock(clock), .reset(reset), .push(push), .pushData(pushData),
    .pop(pop), .clearErrors(clearErrors), .popData(popData0),
    .popValid(popValid0), .full(full0), .empty(empty0),
    .almostFull(aFull0), .almostEmpty(aEmpty0), .fillCount(cnt0),
    .overflow(ovf0), .underflow(udf0));

  fifo_flex #(.nrOfEntries(N), .bitWidth(W), .almostFullLevel(12),
              .almostEmptyLevel(4), .fwft(1)) dut1 (
    .clock(clock), .reset(reset), .push(push), .pushData(pushData),
    .pop(pop), .clearErrors(clearErrors), .popData(popData1),
    .popValid(popValid1), .full(full1), .empty(empty1),
    .almostFull(aFull1), .almostEmpty(aEmpty1), .fillCount(cnt1),
    .overflow(ovf1), .underflow(udf1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic [W-1:0] q[$];
  bit           mOvf, mUdf, mPv;
  logic [W-1:0] mPd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit pu, input bit po, input bit cl,
                      input logic [W-1:0] d);
    bit e, f, pa, wa;
    int sz;
    reset = r; push = pu; pop = po; clearErrors = cl; pushData = d;
    @(posedge clock);
    if (r) begin
      q.delete(); mOvf = 0; mUdf = 0; mPv = 0; mPd = '0;
    end else begin
      e  = (q.size() == 0);
      f  = (q.size() == N);
      pa = po && !e;
      wa = pu && (!f || pa);
      if (pu && !wa) mOvf = 1; else if (cl) mOvf = 0;
      if (po && e)   mUdf = 1; else if (cl) mUdf = 0;
      mPv = pa;
      if (pa) mPd = q.pop_front();
      if (wa) q.push_back(d);
    end
    #1;
    sz = q.size();
    chk("fillCount",   64'(cnt0),   64'(sz));
    chk("full",        64'(full0),  64'(sz == N));
    chk("empty",       64'(empty0), 64'(sz == 0));
    chk("almostFull",  64'(aFull0), 64'(sz >= 12));
    chk("almostEmpty", 64'(aEmpty0),64'(sz <= 4));
    chk("overflow",    64'(ovf0),   64'(mOvf));
    chk("underflow",   64'(udf0),   64'(mUdf));
    chk("popValid",    64'(popValid0), 64'(mPv));
    chk("popData",     64'(popData0),  64'(mPd));
    chk("fwft_fillCount", 64'(cnt1), 64'(sz));
    chk("fwft_errors",    64'({ovf1, udf1}), 64'({mOvf, mUdf}));
    chk("fwft_popValid",  64'(popValid1), 64'(sz != 0));
    chk("fwft_popData",   64'(popData1),  (sz != 0) ? 64'(q[0]) : 64'(0));
  endtask

  typedef struct {
    bit rst, pu, po, cl;
    logic [W-1:0] d;
    int cnt;
    bit ovf, udf, pv;
    logic [W-1:0] pd;
  } vec_t;

  vec_t vec [9];

  initial begin
    // rst  pu po cl  data        cnt ovf udf pv popData
    vec[0] = '{1, 1, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0};
    vec[1] = '{0, 1, 1, 0, 32'h11, 1, 0, 1, 0, 32'h0};  // pop on empty w/ push
    vec[2] = '{0, 0, 0, 1, 32'h0,  1, 0, 0, 0, 32'h0};
    vec[3] = '{0, 0, 1, 0, 32'h0,  0, 0, 0, 1, 32'h11};
    vec[4] = '{0, 0, 1, 1, 32'h0,  0, 0, 1, 0, 32'h11}; // set beats clear
    vec[5] = '{0, 0, 0, 1, 32'h0,  0, 0, 0, 0, 32'h11};
    vec[6] = '{0, 1, 0, 0, 32'h22, 1, 0, 0, 0, 32'h11};
    vec[7] = '{0, 1, 1, 0, 32'h33, 1, 0, 0, 1, 32'h22};
    vec[8] = '{1, 1, 0, 0, 32'h44, 0, 0, 0, 0, 32'h0};  // reset beats push

    reset = 1; push = 0; pop = 0; clearErrors = 0; pushData = '0;

    for (int i = 0; i < 9; i++) begin
      step(vec[i].rst, vec[i].pu, vec[i].po, vec[i].cl, vec[i].d);
      chk("tbl_cnt", 64'(cnt0),      64'(vec[i].cnt));
      chk("tbl_ovf", 64'(ovf0),      64'(vec[i].ovf));
      chk("tbl_udf", 64'(udf0),      64'(vec[i].udf));
      chk("tbl_pv",  64'(popValid0), 64'(vec[i].pv));
      chk("tbl_pd",  64'(popData0),  64'(vec[i].pd));
    end

    // fill / drain with in-order data
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= N; i++) step(0, 1, 0, 0, W'(i));
    chk("fill_full", 64'(full0), 64'(1));
    chk("fill_cnt",  64'(cnt0),  64'(16));
    for (int i = 1; i <= N; i++) begin
      step(0, 0, 1, 0, 0);
      chk("drain_data",  64'(popData0),  64'(i));
      chk("drain_valid", 64'(popValid0), 64'(1));
    end
    step(0, 0, 0, 0, 0);
    chk("drain_valid_drop", 64'(popValid0), 64'(0));
    chk("drain_empty",      64'(empty0),    64'(1));

    // overflow on full, data preserved, clear
    for (int i = 1; i <= N; i++) step(0, 1, 0, 0, W'(i));
    step(0, 1, 0, 0, 32'd99);
    chk("ovf_set", 64'(ovf0), 64'(1));
    chk("ovf_cnt", 64'(cnt0), 64'(16));
    step(0, 0, 0, 1, 0);
    chk("ovf_clr", 64'(ovf0), 64'(0));
    for (int i = 1; i <= N; i++) begin
      step(0, 0, 1, 0, 0);
      chk("ovf_data", 64'(popData0), 64'(i));
    end

    // full with simultaneous push/pop, three full pointer wraps
    for (int i = 0; i < N; i++) step(0, 1, 0, 0, W'(100 + i));
    for (int k = 0; k < 3*N; k++) begin
      step(0, 1, 1, 0, W'(200 + k));
      chk("swap_data", 64'(popData0), (k < N) ? 64'(100 + k) : 64'(200 + k - N));
      chk("swap_cnt",  64'(cnt0), 64'(16));
      chk("swap_ovf",  64'(ovf0), 64'(0));
    end
    for (int i = 0; i < N; i++) begin
      step(0, 0, 1, 0, 0);
      chk("swap_tail", 64'(popData0), 64'(200 + 2*N + i));
    end

    // fall-through latency
    step(1, 0, 0, 0, 0);
    chk("fwft_rst_valid", 64'(popValid1), 64'(0));
    step(0, 1, 0, 0, 32'hA5);
    chk("fwft_data",  64'(popData1),  64'(32'hA5));
    chk("fwft_valid", 64'(popValid1), 64'(1));
    step(0, 0, 0, 0, 0);
    chk("fwft_hold",  64'(popData1),  64'(32'hA5));
    step(0, 0, 1, 0, 0);
    chk("fwft_empty", 64'(empty1),    64'(1));
    chk("fwft_novalid", 64'(popValid1), 64'(0));

    // thresholds and mid-operation reset with a pending sticky error
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("thr_udf", 64'(udf0), 64'(1));
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, W'(i));
    chk("thr_af_11", 64'(aFull0), 64'(0));
    step(0, 1, 0, 0, 32'd11);
    chk("thr_af_12", 64'(aFull0), 64'(1));
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    chk("thr_ae_5", 64'(aEmpty0), 64'(0));
    step(0, 0, 1, 0, 0);
    chk("thr_ae_4", 64'(aEmpty0), 64'(1));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, W'(50 + i));
    chk("thr_cnt7", 64'(cnt0), 64'(7));
    step(1, 1, 0, 0, 32'd77);
    chk("rst_cnt",   64'(cnt0),   64'(0));
    chk("rst_empty", 64'(empty0), 64'(1));
    chk("rst_flags", 64'({full0, aFull0, aEmpty0, ovf0, udf0}), 64'(5'b00100));

    // randomized traffic in alternating fill-biased / drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bit r, pu, po, cl;
      bias = ((i / 300) % 2 == 0) ? 75 : 30;
      pu = ($urandom_range(0, 99) < bias);
      po = ($urandom_range(0, 99) < 100 - bias);
      cl = ($urandom_range(0, 99) < 5);
      r  = ($urandom_range(0, 999) < 5);
      step(r, pu, po, cl, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
